// File: rtl/requant_pkg.sv
// Shared widths, int32 limits and the per-channel requant table entry
// used by the requantisation pipeline.
package requant_pkg;

  localparam int ACC_W   = 32;
  localparam int MULT_W  = 32;
  localparam int SHIFT_W = 6;
  localparam int ACT_W   = 8;

  localparam logic signed [ACC_W-1:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [ACC_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;

  typedef struct packed {
    logic signed [ACC_W-1:0]   bias;
    logic signed [MULT_W-1:0]  mult;
    logic signed [SHIFT_W-1:0] shift;
  } chan_entry_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of the requant datapath: bias/left-shift, Q31 high-mul, rounding
// right shift, offset and clamp. Four registered stages that advance on en.
module requant_lane
  import requant_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] acc,
  input  chan_entry_t             entry,
  input  logic signed [ACC_W-1:0] out_offset,
  input  logic signed [ACT_W-1:0] act_min,
  input  logic signed [ACT_W-1:0] act_max,
`ifdef REQUANT_SAT_STATS_EN
  output logic                    clamped,
`endif
  output logic [ACT_W-1:0]        out_act
);

  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  logic signed [SHIFT_W-1:0] sh;
  logic signed [ACC_W-1:0]   bias;
  logic signed [ACC_W-1:0]   sum1;
  logic signed [ACC_W-1:0]   x1_d;
  logic [4:0]                r1_d;

  logic signed [ACC_W-1:0]   x1;
  logic signed [MULT_W-1:0]  mult1;
  logic [4:0]                r1;

  logic signed [63:0]        x_ext;
  logic signed [63:0]        m_ext;
  logic signed [63:0]        p2;
  logic                      sat2;
  logic [4:0]                r2;

  logic signed [63:0]        sum3;
  logic signed [ACC_W-1:0]   y3_d;
  logic signed [ACC_W-1:0]   y3;
  logic [4:0]                r3;

  logic [ACC_W-1:0]          mask;
  logic [ACC_W-1:0]          rem;
  logic [ACC_W-1:0]          thr;
  logic signed [ACC_W-1:0]   z;
  logic signed [ACC_W-1:0]   o;
  logic signed [ACC_W-1:0]   min_ext;
  logic signed [ACC_W-1:0]   max_ext;
  logic                      lo;
  logic                      hi;
  logic [ACT_W-1:0]          res4_d;

  assign sh   = entry.shift;
  assign bias = entry.bias;

  always_comb begin
    sum1 = acc + bias;
    x1_d = sum1;
    r1_d = 5'(-sh);
    if (sh > 6'sd0) begin
      x1_d = sum1 << sh[4:0];
      r1_d = 5'd0;
    end
  end

  assign x_ext = {{32{x1[31]}}, x1};
  assign m_ext = {{32{mult1[31]}}, mult1};

  // Truncating divide by 2^31: arithmetic shift floors, so bump negative inexact quotients.
  always_comb begin
    sum3 = p2 + (p2[63] ? NUDGE_NEG : NUDGE_POS);
    y3_d = 32'(sum3 >>> 31);
    if (sum3[63] && (sum3[30:0] != '0)) y3_d = y3_d + 32'sd1;
    if (sat2) y3_d = INT32_MAX;
  end

  always_comb begin
    mask    = (32'd1 << r3) - 32'd1;
    rem     = y3 & mask;
    thr     = (mask >> 1) + {31'd0, y3[31]};
    z       = (y3 >>> r3) + ((rem > thr) ? 32'sd1 : 32'sd0);
    o       = z + out_offset;
    min_ext = {{24{act_min[7]}}, act_min};
    max_ext = {{24{act_max[7]}}, act_max};
    lo      = o < min_ext;
    hi      = o > max_ext;
    res4_d  = o[ACT_W-1:0];
    if (lo)      res4_d = act_min;
    else if (hi) res4_d = act_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1      <= '0;
      mult1   <= '0;
      r1      <= '0;
      p2      <= '0;
      sat2    <= 1'b0;
      r2      <= '0;
      y3      <= '0;
      r3      <= '0;
      out_act <= '0;
    end else if (en) begin
      x1      <= x1_d;
      mult1   <= entry.mult;
      r1      <= r1_d;
      p2      <= x_ext * m_ext;
      sat2    <= (x1 == INT32_MIN) && (mult1 == INT32_MIN);
      r2      <= r1;
      y3      <= y3_d;
      r3      <= r2;
      out_act <= res4_d;
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  clamped <= 1'b0;
    else if (en) clamped <= lo || hi;
  end
`endif

endmodule

// File: rtl/requant_pipe.sv
// LANES-wide int32 -> int8 requant pipeline with a per-channel table and a global stall.
// Define REQUANT_SAT_STATS_EN to add the sat_count/sat_clr clamp statistics.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int CH_DEPTH = 64,
  parameter int CH_BITS  = $clog2(CH_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_wr_en,
  input  logic [CH_BITS-1:0]       cfg_addr,
  input  logic [ACC_W-1:0]         cfg_bias,
  input  logic [MULT_W-1:0]        cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [ACC_W-1:0]         out_offset,
  input  logic [ACT_W-1:0]         act_min,
  input  logic [ACT_W-1:0]         act_max,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACC_W*LANES-1:0]   in_acc,
  input  logic [CH_BITS-1:0]       in_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACT_W*LANES-1:0]   out_data,
`ifdef REQUANT_SAT_STATS_EN
  input  logic                     sat_clr,
  output logic [31:0]              sat_count,
`endif
  output logic                     busy
);

  chan_entry_t chan_tbl [CH_DEPTH];

  logic advance;
  logic v1, v2, v3, v4;

  // Table is deliberately not reset; a same-cycle beat sees the old entry.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) chan_tbl[cfg_addr] <= {cfg_bias, cfg_mult, cfg_shift};
  end

  assign advance   = !v4 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v4;
  assign busy      = v1 | v2 | v3 | v4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  logic [LANES-1:0] lane_clamped;
  logic [32:0]      sat_inc;
  logic [32:0]      sat_sum;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CH_BITS-1:0] ch_idx;
    assign ch_idx = in_ch + CH_BITS'(i);

    requant_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (advance),
      .acc        (in_acc[ACC_W*i +: ACC_W]),
      .entry      (chan_tbl[ch_idx]),
      .out_offset (out_offset),
      .act_min    (act_min),
      .act_max    (act_max),
`ifdef REQUANT_SAT_STATS_EN
      .clamped    (lane_clamped[i]),
`endif
      .out_act    (out_data[ACT_W*i +: ACT_W])
    );
  end

`ifdef REQUANT_SAT_STATS_EN
  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < LANES; i++) sat_inc = sat_inc + 33'(lane_clamped[i]);
    sat_sum = {1'b0, sat_count} + sat_inc;
  end

  // Counts clamped lanes per output handshake and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sat_count <= '0;
    else if (sat_clr)           sat_count <= '0;
    else if (v4 && out_ready)   sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_requant_pipe.sv
// Randomised and directed bench for requant_pipe against an arithmetic reference
// model; REQUANT_SAT_STATS_EN also enables the clamp statistics checks.
module tb_requant_pipe;

  localparam int LANES    = 4;
  localparam int CH_DEPTH = 64;
  localparam int INT_MIN  = 32'sh80000000;
  localparam longint HALF30 = 64'sd1073741824;
  localparam longint TWO31  = 64'sd2147483648;

  logic              clk;
  logic              rst_n;
  logic              cfg_wr_en;
  logic [5:0]        cfg_addr;
  logic [31:0]       cfg_bias;
  logic [31:0]       cfg_mult;
  logic [5:0]        cfg_shift;
  logic signed [31:0] out_offset;
  logic signed [7:0] act_min;
  logic signed [7:0] act_max;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_acc;
  logic [5:0]        in_ch;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              busy;
`ifdef REQUANT_SAT_STATS_EN
  logic              sat_clr;
  logic [31:0]       sat_count;
`endif

  int          tbl_bias  [CH_DEPTH];
  int          tbl_mult  [CH_DEPTH];
  int          tbl_shift [CH_DEPTH];
  logic [31:0] exp_q [$];
  int          sat_q [$];
  int          exp_sat;
  int          n_checks;
  int          n_fail;
  int          n_accepted;
  bit          held_valid;
  logic [31:0] held_data;

  requant_pipe #(.LANES(LANES), .CH_DEPTH(CH_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_bias   (cfg_bias),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .out_offset (out_offset),
    .act_min    (act_min),
    .act_max    (act_max),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_acc     (in_acc),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef REQUANT_SAT_STATS_EN
    .sat_clr    (sat_clr),
    .sat_count  (sat_count),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: int32 wrap arithmetic, exact high-mul, round-half-away-from-zero divide.
  function automatic void ref_lane(input int acc, input int ch, output logic [7:0] res, output int clamped);
    int x, y, z, o, r, sh;
    longint p, a, q;
    sh = tbl_shift[ch];
    x  = acc + tbl_bias[ch];
    if (sh > 0) x = x << sh;
    if (x == INT_MIN && tbl_mult[ch] == INT_MIN) y = 32'h7FFFFFFF;
    else begin
      p = longint'(x) * longint'(tbl_mult[ch]);
      p = (p >= 0) ? p + HALF30 : p + 1 - HALF30;
      y = int'(p / TWO31);
    end
    r = (sh <= 0) ? -sh : 0;
    if (r == 0) z = y;
    else begin
      a = (y < 0) ? -longint'(y) : longint'(y);
      q = (a + (longint'(1) << (r - 1))) >>> r;
      z = (y < 0) ? -int'(q) : int'(q);
    end
    o = z + int'(out_offset);
    clamped = 1;
    if (o < int'(act_min))      res = act_min;
    else if (o > int'(act_max)) res = act_max;
    else begin
      res     = o[7:0];
      clamped = 0;
    end
  endfunction

  function automatic void beat_expect(input logic [127:0] acc, input int ch, output logic [31:0] data, output int nsat);
    logic [7:0] r;
    int c;
    nsat = 0;
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      ref_lane(int'(acc[32*i +: 32]), (ch + i) % CH_DEPTH, r, c);
      data[8*i +: 8] = r;
      nsat += c;
    end
  endfunction

  function automatic logic [127:0] rand_acc();
    logic [127:0] v;
    for (int i = 0; i < LANES; i++)
      v[32*i +: 32] = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 4000) - 2000);
    return v;
  endfunction

  task automatic program_ch(input int ch, input int bias, input int mult, input int sh);
    cfg_wr_en = 1'b1;
    cfg_addr  = ch[5:0];
    cfg_bias  = bias;
    cfg_mult  = mult;
    cfg_shift = sh[5:0];
    @(negedge clk);
    cfg_wr_en      = 1'b0;
    tbl_bias[ch]   = bias;
    tbl_mult[ch]   = mult;
    tbl_shift[ch]  = sh;
  endtask

  task automatic apply_stimulus(input logic [127:0] acc, input int ch);
    in_valid = 1'b1;
    in_acc   = acc;
    in_ch    = ch[5:0];
  endtask

  // One cycle of scoreboarding: stall stability, in_ready rule, push on accept, pop on output.
  task automatic tick();
    logic [31:0] d;
    int n;
    #1;
    if (held_valid) begin
      check_output("hold_valid", out_valid, 1);
      check_output("hold_data", out_data, held_data);
    end
    check_output("in_ready", in_ready, !(out_valid && !out_ready));
    if (in_valid && in_ready) begin
      beat_expect(in_acc, int'(in_ch), d, n);
      exp_q.push_back(d);
      sat_q.push_back(n);
      n_accepted++;
    end
    if (out_valid && out_ready) begin
      check_output("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        n = sat_q.pop_front();
        check_output("out_data", out_data, d);
        exp_sat += n;
      end
    end
    held_valid = out_valid && !out_ready;
    held_data  = out_data;
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [127:0] acc, input int ch, input logic [31:0] lit);
    int waited;
    waited = 0;
    out_ready = 1'b1;
    apply_stimulus(acc, ch);
    tick();
    in_valid = 1'b0;
    if (cfg_wr_en) begin
      tbl_bias[cfg_addr]  = cfg_bias;
      tbl_mult[cfg_addr]  = cfg_mult;
      tbl_shift[cfg_addr] = int'($signed(cfg_shift));
      cfg_wr_en = 1'b0;
    end
    while (!out_valid && waited < 10) begin
      tick();
      waited++;
    end
    check_output({tag, "_latency"}, waited, 3);
    check_output(tag, out_data, lit);
    tick();
  endtask

  initial begin
    int base;
    int prev;
    logic [127:0] beat_acc;
    int beat_ch;

    n_checks = 0; n_fail = 0; n_accepted = 0; exp_sat = 0;
    held_valid = 1'b0; held_data = '0;
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    out_offset = '0; act_min = -8'sd128; act_max = 8'sd127;
    in_valid = 1'b0; in_acc = '0; in_ch = '0; out_ready = 1'b1;
`ifdef REQUANT_SAT_STATS_EN
    sat_clr = 1'b0;
`endif
    #1;
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic requant and clamp boundaries");
    out_offset = -128;
    for (int c = 0; c < 4; c++) program_ch(c, 0, 32'h40000000, 0);
    run_one("basic", {32'd1000, 32'hFFFFFF9C, 32'd0, 32'd100}, 0, 32'h7F8080B2);

    $display("[TB] rounding half away from zero");
    out_offset = 0;
    for (int c = 0; c < 4; c++) program_ch(c, 0, 32'h7FFFFFFF, -1);
    run_one("round", {32'hFFFFFFFB, 32'd5, 32'hFFFFFFFB, 32'd5}, 0, 32'hFD03FD03);

    $display("[TB] saturating high-mul");
    for (int c = 0; c < 4; c++) program_ch(c, 0, 32'h80000000, 0);
    run_one("sat_highmul", {32'd0, 32'd0, 32'd0, 32'h80000000}, 0, 32'h0000007F);
`ifdef REQUANT_SAT_STATS_EN
    check_output("sat_count_directed", sat_count, exp_sat);
`endif

    $display("[TB] per-channel lanes with wrap and same-cycle write");
    program_ch(62, 10, 32'h40000000, 0);
    program_ch(63, 20, 32'h40000000, 0);
    program_ch(0, 30, 32'h40000000, 0);
    program_ch(1, 40, 32'h40000000, 0);
    cfg_wr_en = 1'b1; cfg_addr = 6'd62; cfg_bias = 100; cfg_mult = 32'h40000000; cfg_shift = 6'd0;
    run_one("perch_samecycle", '0, 62, 32'h140F0A05);
    run_one("perch_newbias", '0, 62, 32'h140F0A32);

    $display("[TB] random stream with backpressure");
    for (int c = 0; c < CH_DEPTH; c++)
      program_ch(c, $urandom, $urandom, int'($urandom_range(0, 40)) - 31);
    out_offset = int'($urandom_range(0, 40)) - 20;
    act_min = -8'sd100;
    act_max = 8'sd90;
    base = n_accepted;
    beat_acc = rand_acc();
    beat_ch = $urandom_range(0, 63);
    for (int c = 0; c < 300; c++) begin
      if (n_accepted - base >= 10 && exp_q.size() == 0) break;
      out_ready = $urandom_range(0, 1);
      if (n_accepted - base < 10) apply_stimulus(beat_acc, beat_ch);
      else in_valid = 1'b0;
      prev = n_accepted;
      tick();
      if (n_accepted != prev) begin
        beat_acc = rand_acc();
        beat_ch = $urandom_range(0, 63);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_output("stream_accepted", n_accepted - base, 10);
    check_output("stream_drained", exp_q.size(), 0);

`ifdef REQUANT_SAT_STATS_EN
    check_output("sat_count_stream", sat_count, exp_sat);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    exp_sat = 0;
    check_output("sat_clr", sat_count, exp_sat);
`endif

    $display("[TB] asynchronous reset with beats in flight");
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      apply_stimulus(rand_acc(), b);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_output("pre_reset_valid", out_valid, 1);
    check_output("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", out_valid, 0);
    check_output("async_reset_busy", busy, 0);
    check_output("async_reset_data", out_data, 0);
    exp_q.delete();
    sat_q.delete();
    held_valid = 1'b0;
    exp_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    out_offset = -128;
    act_min = -8'sd128;
    act_max = 8'sd127;
    for (int c = 0; c < 4; c++) program_ch(c, 0, 32'h40000000, 0);
    run_one("post_reset", {4{32'd100}}, 0, 32'hB2B2B2B2);
    check_output("post_reset_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
